// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback FIFOs.
// Optional per-requester grant / conflict statistics when WB_STATS_EN is defined.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_wr,
    input  logic [DATA_W-1:0] alu_wd,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wr,
    input  logic [DATA_W-1:0] mem_wd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    output logic [31:0]       pend_mask
`ifdef WB_STATS_EN
    ,
    output logic [15:0]       stat_alu_wr,
    output logic [15:0]       stat_mem_wr,
    output logic [15:0]       stat_conflict
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MEM = 1'b1
    } rr_e;

    rr_e rr_q, rr_d;

    logic [ADDR_W-1:0] fifo_wr_q [2][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wd_q [2][FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_q     [2];
    logic [CNT_W-1:0]  cnt_d     [2];
    logic [PTR_W-1:0]  rd_ptr_q  [2];
    logic [PTR_W-1:0]  rd_ptr_d  [2];
    logic [PTR_W-1:0]  wr_ptr_q  [2];
    logic [PTR_W-1:0]  wr_ptr_d  [2];

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_wr [2];
    logic [DATA_W-1:0] in_wd [2];
    logic [1:0]        full;
    logic [1:0]        nonempty;
    logic [1:0]        push;
    logic [1:0]        grant;

    assign in_valid = {mem_valid, alu_valid};
    assign in_wr[0] = alu_wr;
    assign in_wr[1] = mem_wr;
    assign in_wd[0] = alu_wd;
    assign in_wd[1] = mem_wd;

    assign full     = {cnt_q[1] == CNT_W'(FIFO_DEPTH), cnt_q[0] == CNT_W'(FIFO_DEPTH)};
    assign nonempty = {cnt_q[1] != '0, cnt_q[0] != '0};

    // Writes to x0 are acknowledged but dropped; flush also drops a same-edge enqueue.
    assign push[0] = in_valid[0] && !full[0] && (in_wr[0] != '0) && !flush;
    assign push[1] = in_valid[1] && !full[1] && (in_wr[1] != '0) && !flush;

    assign grant[0] = nonempty[0] && (!nonempty[1] || (rr_q == RR_ALU));
    assign grant[1] = nonempty[1] && (!nonempty[0] || (rr_q == RR_MEM));

    assign alu_ready = !full[0] || !rst_n;
    assign mem_ready = !full[1] || !rst_n;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rr_d = rr_q;
        if ((&nonempty) && !flush) begin
            rr_d = (rr_q == RR_ALU) ? RR_MEM : RR_ALU;
        end
        for (int r = 0; r < 2; r++) begin
            cnt_d[r]    = cnt_q[r];
            rd_ptr_d[r] = rd_ptr_q[r];
            wr_ptr_d[r] = wr_ptr_q[r];
            if (push[r]) wr_ptr_d[r] = wr_ptr_q[r] + PTR_W'(1);
            if (grant[r]) rd_ptr_d[r] = rd_ptr_q[r] + PTR_W'(1);
            if (push[r] && !grant[r]) cnt_d[r] = cnt_q[r] + CNT_W'(1);
            else if (!push[r] && grant[r]) cnt_d[r] = cnt_q[r] - CNT_W'(1);
            if (flush) begin
                cnt_d[r]    = '0;
                rd_ptr_d[r] = '0;
                wr_ptr_d[r] = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= RR_ALU;
            for (int r = 0; r < 2; r++) begin
                cnt_q[r]    <= '0;
                rd_ptr_q[r] <= '0;
                wr_ptr_q[r] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int r = 0; r < 2; r++) begin
                cnt_q[r]    <= cnt_d[r];
                rd_ptr_q[r] <= rd_ptr_d[r];
                wr_ptr_q[r] <= wr_ptr_d[r];
            end
        end
    end

    // NOTE: FIFO storage has no reset; occupancy counters alone decide which slots are valid.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                fifo_wr_q[r][wr_ptr_q[r]] <= in_wr[r];
                fifo_wd_q[r][wr_ptr_q[r]] <= in_wd[r];
            end
        end
    end

    always_comb begin
        rf_we = rst_n && (|grant);
        rf_wr = '0;
        rf_wd = '0;
        if (rst_n && grant[1]) begin
            rf_wr = fifo_wr_q[1][rd_ptr_q[1]];
            rf_wd = fifo_wd_q[1][rd_ptr_q[1]];
        end else if (rst_n && grant[0]) begin
            rf_wr = fifo_wr_q[0][rd_ptr_q[0]];
            rf_wd = fifo_wd_q[0][rd_ptr_q[0]];
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pend_mask = '0;
        if (rst_n) begin
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q[r])) < cnt_q[r]) begin
                        pend_mask = pend_mask | (32'(1) << fifo_wr_q[r][i]);
                    end
                end
            end
        end
        pend_mask[0] = 1'b0;
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_alu_wr   <= '0;
            stat_mem_wr   <= '0;
            stat_conflict <= '0;
        end else begin
            if (grant[0] && (stat_alu_wr != 16'hFFFF)) stat_alu_wr <= stat_alu_wr + 16'd1;
            if (grant[1] && (stat_mem_wr != 16'hFFFF)) stat_mem_wr <= stat_mem_wr + 16'd1;
            if ((&nonempty) && (stat_conflict != 16'hFFFF)) stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued as stimulus is accepted
// and compared against the writes observed on the register-file port.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_wr;
    logic [31:0] alu_wd;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_wr;
    logic [31:0] mem_wd;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;
`ifdef WB_STATS_EN
    logic [15:0] stat_alu_wr, stat_mem_wr, stat_conflict;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  wr;
        logic [31:0] wd;
    } wb_t;

    wb_t obs_q[$];
    wb_t exp_q[$];
    wb_t exp_mem_q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wr(alu_wr), .alu_wd(alu_wd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_wd(mem_wd),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .pend_mask(pend_mask)
`ifdef WB_STATS_EN
        , .stat_alu_wr(stat_alu_wr), .stat_mem_wr(stat_mem_wr), .stat_conflict(stat_conflict)
`endif
    );

    always @(negedge clk) if (rf_we === 1'b1) obs_q.push_back({rf_wr, rf_wd});

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        flush = 1'b0;
        alu_valid = 1'b0; alu_wr = '0; alu_wd = '0;
        mem_valid = 1'b0; mem_wr = '0; mem_wd = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        obs_q.delete(); exp_q.delete(); exp_mem_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        checks++; if (rf_wr !== 5'd0) begin errors++; $display("FAIL reset_rf_wr: got %h want 0", rf_wr); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd: got %h want 0", rf_wd); end
        checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL reset_pend: got %h want 0", pend_mask); end
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
            errors++; $display("FAIL post_reset_idle: got we=%b pend=%h want 0/0", rf_we, pend_mask);
        end
`ifdef WB_STATS_EN
        checks++; if (stat_alu_wr !== 16'd0 || stat_mem_wr !== 16'd0 || stat_conflict !== 16'd0) begin
            errors++; $display("FAIL reset_stats: got %h %h %h want 0", stat_alu_wr, stat_mem_wr, stat_conflict);
        end
`endif
        step();
    endtask

    task automatic test_single_write();
        wb_t e, o;
        apply_reset();
        alu_valid = 1'b1; alu_wr = 5'd5; alu_wd = 32'h11;
        @(negedge clk);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", alu_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_no_passthrough: got we=%b want 0", rf_we); end
        if (alu_ready === 1'b1) exp_q.push_back({5'd5, 32'h11});
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd5 || rf_wd !== 32'h11) begin
            errors++; $display("FAIL single_write: got we=%b wr=%0d wd=%h want 1/5/11", rf_we, rf_wr, rf_wd);
        end
        checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend: got %h want 00000020", pend_mask); end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
            errors++; $display("FAIL single_drained: got we=%b pend=%h want 0/0", rf_we, pend_mask);
        end
        step();
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_sb_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_conflict();
        wb_t e, o;
        apply_reset();
        alu_valid = 1'b1; alu_wr = 5'd1; alu_wd = 32'hA;
        mem_valid = 1'b1; mem_wr = 5'd2; mem_wd = 32'hB;
        exp_q.push_back({5'd1, 32'hA});
        exp_q.push_back({5'd2, 32'hB});
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd1 || rf_wd !== 32'hA) begin
            errors++; $display("FAIL conflict_first: got we=%b wr=%0d wd=%h want 1/1/a", rf_we, rf_wr, rf_wd);
        end
        checks++; if (pend_mask !== 32'h6) begin errors++; $display("FAIL conflict_pend: got %h want 00000006", pend_mask); end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd2 || rf_wd !== 32'hB) begin
            errors++; $display("FAIL conflict_second: got we=%b wr=%0d wd=%h want 1/2/b", rf_we, rf_wr, rf_wd);
        end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL conflict_idle: got we=%b want 0", rf_we); end
`ifdef WB_STATS_EN
        checks++; if (stat_conflict !== 16'd1 || stat_alu_wr !== 16'd1 || stat_mem_wr !== 16'd1) begin
            errors++; $display("FAIL conflict_stats: got c=%0d a=%0d m=%0d want 1/1/1", stat_conflict, stat_alu_wr, stat_mem_wr);
        end
`endif
        step();
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL conflict_sb_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL conflict_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        int ai = 0;
        int mi = 0;
        int cyc = 0;
        logic [3:0] ardy_seen = '0;
        logic [3:0] src_seen = '0;
        wb_t o, e;
        wb_t obs_alu[$];
        wb_t obs_mem[$];
        apply_reset();
        while ((ai < 4 || mi < 6 || obs_q.size() < 10) && cyc < 40) begin
            alu_valid = (ai < 4); alu_wr = 5'(8 + ai);  alu_wd = 32'(32'hA000 + ai);
            mem_valid = (mi < 6); mem_wr = 5'(16 + mi); mem_wd = 32'(32'hB000 + mi);
            @(negedge clk);
            if (cyc < 4) ardy_seen[cyc] = alu_ready;
            if (alu_valid && alu_ready) begin exp_q.push_back({alu_wr, alu_wd}); ai++; end
            if (mem_valid && mem_ready) begin exp_mem_q.push_back({mem_wr, mem_wd}); mi++; end
            step();
            cyc++;
        end
        idle_inputs();
        checks++; if (cyc >= 40) begin errors++; $display("FAIL bp_timeout: got %0d cycles want <40", cyc); end
        checks++; if (ardy_seen !== 4'b0111) begin
            errors++; $display("FAIL bp_alu_ready: got %b want 0111 (cycle3..0)", ardy_seen);
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) src_seen[i] = obs_q[i].wr[4];
        checks++; if (src_seen !== 4'b1010) begin
            errors++; $display("FAIL bp_alternate: got %b want 1010 (grant3..0, 1=mem)", src_seen);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.wr[4]) obs_mem.push_back(o); else obs_alu.push_back(o);
        end
        checks++; if (obs_alu.size() != exp_q.size() || obs_mem.size() != exp_mem_q.size()) begin
            errors++; $display("FAIL bp_sb_count: got alu=%0d mem=%0d want %0d/%0d",
                               obs_alu.size(), obs_mem.size(), exp_q.size(), exp_mem_q.size());
        end
        while (exp_q.size() > 0 && obs_alu.size() > 0) begin
            e = exp_q.pop_front(); o = obs_alu.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bp_alu_order: got %h want %h", o, e); end
        end
        while (exp_mem_q.size() > 0 && obs_mem.size() > 0) begin
            e = exp_mem_q.pop_front(); o = obs_mem.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bp_mem_order: got %h want %h", o, e); end
        end
    endtask

    task automatic test_x0();
        apply_reset();
        alu_valid = 1'b1; alu_wr = 5'd0; alu_wd = 32'hDEAD;
        @(negedge clk);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", alu_ready); end
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
            errors++; $display("FAIL x0_dropped: got we=%b pend=%h want 0/0", rf_we, pend_mask);
        end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_later: got we=%b want 0", rf_we); end
        step();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL x0_sb_count: got %0d writes want 0", obs_q.size()); end
    endtask

    task automatic test_flush();
        wb_t e, o;
        apply_reset();
        alu_valid = 1'b1; alu_wr = 5'd3; alu_wd = 32'h33;
        mem_valid = 1'b1; mem_wr = 5'd4; mem_wd = 32'h44;
        exp_q.push_back({5'd3, 32'h33});
        step();
        alu_valid = 1'b0;
        flush = 1'b1; mem_valid = 1'b1; mem_wr = 5'd6; mem_wd = 32'h66;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd3 || rf_wd !== 32'h33) begin
            errors++; $display("FAIL flush_cycle_write: got we=%b wr=%0d wd=%h want 1/3/33", rf_we, rf_wr, rf_wd);
        end
        checks++; if (pend_mask !== 32'h18) begin errors++; $display("FAIL flush_pend_before: got %h want 00000018", pend_mask); end
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'd0 || alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty: got we=%b pend=%h rdy=%b%b want 0/0/11", rf_we, pend_mask, alu_ready, mem_ready);
        end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_later: got we=%b want 0", rf_we); end
        step();
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL flush_sb_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL flush_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        wb_t e, o;
        apply_reset();
        alu_valid = 1'b1; alu_wr = 5'd9;  alu_wd = 32'h99;
        mem_valid = 1'b1; mem_wr = 5'd10; mem_wd = 32'hAA;
        exp_q.push_back({5'd9, 32'h99});
        step();
        alu_wr = 5'd11; alu_wd = 32'hBB;
        mem_wr = 5'd12; mem_wd = 32'hCC;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd9) begin
            errors++; $display("FAIL rstmid_grant: got we=%b wr=%0d want 1/9", rf_we, rf_wr);
        end
        checks++; if (pend_mask !== 32'h600) begin errors++; $display("FAIL rstmid_pend: got %h want 00000600", pend_mask); end
        step();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_during: got we=%b want 0", rf_we); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || pend_mask !== 32'd0 || alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_after: got we=%b pend=%h rdy=%b%b want 0/0/11", rf_we, pend_mask, alu_ready, mem_ready);
        end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_later: got we=%b want 0", rf_we); end
        step();
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rstmid_sb_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rstmid_sb: got %h want %h", o, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_conflict();
        test_backpressure();
        test_x0();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
